// File: rtl/mult_seq_unit.sv
// mult_seq_unit: iterative shift-add multiplier and sequencer for the DLX EX-stage
// Mult group (signed MULT and unsigned MULTU).
//
// A multiply is accepted when a legal Mult-group instruction is in EX. The unit
// holds the pipeline via stall while it works, then pulses result_valid for one
// cycle. Latency is WIDTH+1 cycles from the accept edge.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           Mult-group instruction valid in EX (held while stalled)
//   funct           funct field of the EX instruction
//   op_a, op_b      forwarded rs / rt operands
//   dest_in         rd of the EX instruction
//   flush           EX-stage flush; kills any in-flight operation
//   stall           freeze PC/IF/ID/EX pipeline registers
//   busy            iterating
//   illegal_funct   start in IDLE with an unsupported funct
//   result_valid    one-cycle pulse when result/result_hi/result_reg are valid
//   result          low WIDTH bits of the product
//   result_hi       high WIDTH bits of the product
//   result_reg      destination register for the write-back
module mult_seq_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 6,
    parameter logic [5:0]  F_MULT  = 6'h0e,
    parameter logic [5:0]  F_MULTU = 6'h16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       dest_in,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             illegal_funct,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       result_reg
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic [4:0]           dest_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     result_hi_q;
    logic [4:0]           result_reg_q;

    logic                 legal;
    logic                 is_signed;
    logic                 accept;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   product;

    assign legal     = (funct == F_MULT) || (funct == F_MULTU);
    assign is_signed = (funct == F_MULT);
    assign accept    = (state_q == StIdle) && start && legal && !flush;

    // Magnitudes; negating the most-negative value yields 2^(WIDTH-1), which is
    // the correct unsigned magnitude.
    assign a_mag = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    assign product = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q == StBusy);
        stall         = accept || busy;
        illegal_funct = (state_q == StIdle) && start && !legal;
        result_valid  = (state_q == StDone) && !flush;
        // While valid, present the fresh product; otherwise hold the last one.
        result        = result_valid ? product[WIDTH-1:0]       : result_q;
        result_hi     = result_valid ? product[2*WIDTH-1:WIDTH] : result_hi_q;
        result_reg    = result_valid ? dest_q                   : result_reg_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            neg_q        <= 1'b0;
            dest_q       <= '0;
            result_q     <= '0;
            result_hi_q  <= '0;
            result_reg_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        dest_q   <= dest_in;
                        neg_q    <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StBusy: begin
                    if (!flush) begin
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (result_valid) begin
                        result_q     <= product[WIDTH-1:0];
                        result_hi_q  <= product[2*WIDTH-1:WIDTH];
                        result_reg_q <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_unit.sv
module tb_mult_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic [4:0]   dest_in;
    logic         stall, busy, illegal_funct, result_valid;
    logic [W-1:0] result, result_hi;
    logic [4:0]   result_reg;

    mult_seq_unit #(.WIDTH(W), .CNT_W(6), .F_MULT(6'h0e), .F_MULTU(6'h16)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .op_a(op_a), .op_b(op_b),
        .dest_in(dest_in), .flush(flush), .stall(stall), .busy(busy),
        .illegal_funct(illegal_funct), .result_valid(result_valid), .result(result),
        .result_hi(result_hi), .result_reg(result_reg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [4:0]   rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got result 0x%0h expected no result",
                         result);
            end else begin
                mon_e = sb.pop_front();
                check("result", {32'h0, result}, {32'h0, mon_e.lo});
                check("result_hi", {32'h0, result_hi}, {32'h0, mon_e.hi});
                check("result_reg", {59'h0, result_reg}, {59'h0, mon_e.rd});
            end
        end
    end

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input logic [W-1:0] lo,
                          input logic [W-1:0] hi, input string name);
        int   errs;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; funct = f; op_a = a; op_b = b; dest_in = rd;
        e.lo = lo; e.hi = hi; e.rd = rd;
        sb.push_back(e);
        errs = 0;
        @(negedge clk);
        if (stall !== 1'b1 || result_valid !== 1'b0) errs++;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (c <= W) begin
                if (stall !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0) errs++;
            end else begin
                if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b1) errs++;
            end
        end
        check({name, " stall/valid timing errors"}, 64'(errs), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({name, " idle after done"}, {61'h0, busy, stall, result_valid}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct = 6'h0; op_a = '0; op_b = '0; dest_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {busy, stall, result_valid, illegal_funct, result_reg},
              64'd0);
        check("reset result", {result_hi, result}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op(6'h16, 32'd7, 32'd6, 5'd5, 32'd42, 32'd0, "multu 7*6");
        run_op(6'h0e, 32'hFFFFFFFD, 32'd5, 5'd1, 32'hFFFFFFF1, 32'hFFFFFFFF, "mult -3*5");
        run_op(6'h16, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFE, 32'h00000001, "multu ff*2");
        run_op(6'h0e, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, "mult -1*2");
        run_op(6'h0e, 32'h80000000, 32'h80000000, 5'd31, 32'h0, 32'h40000000, "mult min*min");
        run_op(6'h0e, 32'hFFFFFFF9, 32'hFFFFFFFA, 5'd6, 32'd42, 32'd0, "mult -7*-6");
        run_op(6'h0e, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd7, 32'h00000001, 32'h3FFFFFFF,
               "mult max*max");
        run_op(6'h16, 32'd0, 32'h12345678, 5'd8, 32'd0, 32'd0, "multu zero");

        // Flush in BUSY: accept at cycle 0, flush in cycle 10.
        @(posedge clk); #1;
        start = 1'b1; funct = 6'h16; op_a = 32'd9; op_b = 32'd9; dest_in = 5'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush cycle busy", {62'h0, busy, result_valid}, 64'd2);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("after busy flush idle", {62'h0, busy, stall}, 64'd0);
        repeat (40) @(negedge clk);
        run_op(6'h16, 32'd9, 32'd9, 5'd4, 32'd81, 32'd0, "multu 9*9 after flush");

        // Flush in DONE: valid suppressed, outputs hold the 81 result.
        @(posedge clk); #1;
        start = 1'b1; funct = 6'h16; op_a = 32'd3; op_b = 32'd4; dest_in = 5'd9;
        repeat (W + 1) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("done flush valid", {62'h0, result_valid, stall}, 64'd0);
        check("done flush hold", {27'h0, result_reg, result}, {27'h0, 5'd4, 32'd81});
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("after done flush", {26'h0, busy, result_reg, result}, {27'h0, 5'd4, 32'd81});

        // Illegal funct.
        @(posedge clk); #1;
        start = 1'b1; funct = 6'h0f; op_a = 32'd2; op_b = 32'd3; dest_in = 5'd10;
        @(negedge clk);
        check("illegal flags", {61'h0, illegal_funct, stall, busy}, 64'd4);
        @(negedge clk);
        check("illegal no state change", {61'h0, illegal_funct, stall, busy}, 64'd4);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("illegal clear", {63'h0, illegal_funct}, 64'd0);

        // Reset in cycle 5 of a legal op.
        @(posedge clk); #1;
        start = 1'b1; funct = 6'h16; op_a = 32'd5; op_b = 32'd5; dest_in = 5'd7;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset mid-op flags", {61'h0, busy, stall, result_valid}, 64'd0);
        check("reset mid-op result", {result_hi, result}, 64'd0);
        check("reset mid-op result_reg", {59'h0, result_reg}, 64'd0);
        repeat (40) @(negedge clk);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
